uart_hex_sender: RTL

- Transmit-direction companion to the UART receive/adder datapath: serializes an 8-bit result onto the RS-232 tx line as printable ASCII hex, optionally followed by CR LF.
- Contains its own bit-period counter, character sequencer and 8N1/8N2 framer, so a computed byte can be reported to the host terminal without going through the TX FIFO.
- Sits beside the UART core in the top level; its tx output is muxed or OR-gated onto the board Tx pin by the top level.

---
 rtl/uart_hex_sender.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_hex_sender.sv
// uart_hex_sender: reports one byte to a terminal as two ASCII hex digits, optionally followed by CR LF.
// Latency: tx drops to the start bit one cycle after an accepted send; the message lasts NCHAR*(9+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: none; send is sampled only while idle, and a send during a message is dropped, not queued.
//
// Ports:
//   clk_100MHz  system clock, rising edge
//   reset       asynchronous, active-high
//   send        request pulse, sampled only in IDLE
//   data        byte to report, latched when send is accepted
//   tx          serial line, idle high, registered
//   busy        high while a message is in progress
//   done        one-cycle pulse in the first idle cycle after the last stop bit
module uart_hex_sender #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int STOP_BITS    = 1,
  parameter bit APPEND_CRLF  = 1'b1
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // One counter serves both the single bit period and the longer stop period,
  // so it is sized for the stop period (which is at least one bit period).
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = (STOP_CLKS > 2) ? $clog2(STOP_CLKS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [1:0]       LAST_CHAR = APPEND_CRLF ? 2'd3 : 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       char_idx;
  logic [7:0]       data_q;
  logic [7:0]       shift_q;

  // Uppercase hex digit: '0'..'9' then 'A'..'F' ('A' - 10 = 0x37).
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n <= 4'd9) begin
      hex_char = 8'h30 + {4'h0, n};
    end else begin
      hex_char = 8'h37 + {4'h0, n};
    end
  endfunction

  // Character at position idx of the message for byte b.
  function automatic logic [7:0] char_at(input logic [1:0] idx, input logic [7:0] b);
    case (idx)
      2'd0:    char_at = hex_char(b[7:4]);
      2'd1:    char_at = hex_char(b[3:0]);
      2'd2:    char_at = 8'h0D;
      default: char_at = 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      data_q   <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (send) begin
            data_q   <= data;
            // First character is built from the live input so it is ready
            // in the same edge that starts the start bit.
            shift_q  <= hex_char(data[7:4]);
            char_idx <= 2'd0;
            clk_cnt  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            tx      <= shift_q[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // tx always shows shift_q[0]; load the next bit before shifting.
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (clk_cnt == STOP_LAST) begin
            clk_cnt <= '0;
            if (char_idx == LAST_CHAR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              char_idx <= char_idx + 2'd1;
              shift_q  <= char_at(char_idx + 2'd1, data_q);
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
